pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central sequencer for the 5-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.
- Produces per-stage enable and flush signals.
- Handles three events: load-use stalls, taken-branch flushes, and multi-cycle data-memory accesses through a req/ready handshake with timeout.
- Keeps stall and flush performance counters for the debug bus.

Parameters:
MEM_TIMEOUT, 255, consecutive unanswered request cycles before error; 0 disables timeout; legal values 0 or >=2
CNT_W, 32, width of the performance counters

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-low
idex_MemRead  input  1  instruction in EX is a load
idex_Rt  input  5  load destination register in EX
ifid_Rs  input  5  source register of instruction in ID
ifid_Rt  input  5  second source register of instruction in ID
ex_BranchTaken  input  1  branch resolved taken in EX this cycle
exmem_MemRead  input  1  MEM-stage instruction reads data memory
exmem_MemWrite  input  1  MEM-stage instruction writes data memory
dmem_ready  input  1  data memory completes the access this cycle
pc_en  output  1  PC load enable
ifid_en, idex_en, exmem_en, memwb_en  output  1 each  pipeline register load enables
ifid_flush, idex_flush, exmem_flush, memwb_flush  output  1 each  register loads zeros on next edge; overrides en
dmem_req  output  1  data memory request
mem_err  output  1  sticky timeout error
stall_cycles  output  CNT_W  cycles with pc_en=0 in RUN or MEM_WAIT, saturating
flush_count  output  CNT_W  taken-branch flush events, saturating

Behaviour:
- Reset is synchronous, active-low (reset=0 resets) on clk.
- While reset=0:
  - state=RUN, wait_cnt=0, counters=0, mem_err=0, dmem_req=0.
  - All enables (pc_en, *_en) are 0.
  - All four flushes are 1, so the pipeline clears.
- Outputs other than counters and mem_err are combinational from state and inputs.
- States: RUN, MEM_WAIT, ERR.
- Definitions:
  - mem_acc = exmem_MemRead | exmem_MemWrite.
  - load_use = idex_MemRead & (idex_Rt != 0) & (idex_Rt == ifid_Rs | idex_Rt == ifid_Rt).
- RUN, priority from highest to lowest:
  1. mem_acc & !dmem_ready:
     - dmem_req=1, all enables 0, all flushes 0.
     - Next state MEM_WAIT, wait_cnt <= 1.
  2. ex_BranchTaken:
     - All enables 1, ifid_flush=1, idex_flush=1.
     - flush_count +1.
     - The PC loads the branch target.
  3. load_use:
     - pc_en=0, ifid_en=0; idex_en=1, idex_flush=1 (bubble); exmem_en=1, memwb_en=1.
     - Exactly one bubble results, because idex_MemRead is 0 in the next cycle.
  4. Otherwise all enables 1, all flushes 0.
  - dmem_req = mem_acc in every RUN cycle.
  - mem_acc with dmem_ready=1 is a zero-wait access; priorities 2-4 then apply in the same cycle.
- MEM_WAIT:
  - dmem_req=1; all enables 0 and all flushes 0 (full freeze).
  - Branch and load-use inputs are ignored; they are re-evaluated on the release cycle.
  - MEM/WB stays frozen; repeated writeback of the same register is idempotent.
  - dmem_ready=1: this is the release cycle. Outputs follow RUN priorities 2-4, the request counts as satisfied, and next state is RUN.
  - dmem_ready=0 and (MEM_TIMEOUT==0 or wait_cnt != MEM_TIMEOUT-1): wait_cnt +1 and stay.
  - dmem_ready=0 and wait_cnt == MEM_TIMEOUT-1: next state ERR. Ready in that same cycle wins over timeout.
- ERR:
  - All enables 0, flushes 0, dmem_req=0, mem_err=1.
  - Exits only on reset.
- Counters:
  - stall_cycles increments on each RUN/MEM_WAIT cycle with pc_en=0.
  - Both counters saturate at all-ones.
- Reset asserted mid-wait returns the block to RUN with counters cleared; any outstanding memory access is abandoned.

Test Plan:
- Load-use: idex_MemRead=1, idex_Rt=8, ifid_Rs=8, dmem idle -> one cycle of pc_en=0, ifid_en=0, idex_flush=1; stall_cycles=1; next cycle all enables 1.
- Load-use with idex_Rt=0, ifid_Rs=0 -> no stall, all enables 1.
- Branch and load_use in the same cycle -> ifid_flush=1, idex_flush=1, pc_en=1; flush_count=1; stall_cycles unchanged.
- exmem_MemRead=1, dmem_ready low for 3 cycles then high:
  - dmem_req high for 4 cycles, enables 0 for 3 cycles, stall_cycles=3.
  - Release cycle has all enables 1, then state returns to RUN.
- MEM_TIMEOUT=4, exmem_MemWrite=1, dmem_ready never set -> ERR after 4 request cycles; mem_err=1, dmem_req=0, enables stay 0; reset=0 for 1 cycle clears mem_err.
- Branch during MEM_WAIT with ready on cycle 2 -> no flush while waiting; flush issued on the release cycle; flush_count=1.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard sequencer: per-stage enables/flushes for load-use stalls, branch flushes
// and data-memory wait states with timeout, plus saturating stall/flush counters.
module pipe_hazard_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 255,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             idex_MemRead,
   input  logic [4:0]       idex_Rt,
   input  logic [4:0]       ifid_Rs,
   input  logic [4:0]       ifid_Rt,
   input  logic             ex_BranchTaken,
   input  logic             exmem_MemRead,
   input  logic             exmem_MemWrite,
   input  logic             dmem_ready,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             idex_en,
   output logic             exmem_en,
   output logic             memwb_en,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             exmem_flush,
   output logic             memwb_flush,
   output logic             dmem_req,
   output logic             mem_err,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_count
);

   localparam int unsigned WC_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
   localparam bit          TO_EN = (MEM_TIMEOUT != 0);
   localparam logic [WC_W-1:0] WC_LAST = WC_W'(MEM_TIMEOUT - 1);

   typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;

   state_t            state, state_next;
   logic [WC_W-1:0]   wait_cnt, wait_next;
   logic              mem_acc, load_use, use_prio, flush_evt, stall_evt;

   assign mem_acc  = exmem_MemRead | exmem_MemWrite;
   assign load_use = idex_MemRead & (idex_Rt != 5'd0) &
                     ((idex_Rt == ifid_Rs) | (idex_Rt == ifid_Rt));

   // Next state and combinational stage controls
   always_comb begin
      state_next  = state;
      wait_next   = wait_cnt;
      use_prio    = 1'b0;
      flush_evt   = 1'b0;
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_en    = 1'b0;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
      memwb_flush = 1'b0;
      dmem_req    = 1'b0;

      case (state)
         RUN: begin
            dmem_req = mem_acc;
            if (mem_acc && !dmem_ready) begin
               state_next = MEM_WAIT;
               wait_next  = WC_W'(1);
            end else begin
               use_prio = 1'b1;
            end
         end
         MEM_WAIT: begin
            dmem_req = 1'b1;
            if (dmem_ready) begin
               use_prio   = 1'b1;
               state_next = RUN;
            end else if (TO_EN && (wait_cnt == WC_LAST)) begin
               state_next = ERR;
            end else begin
               wait_next = wait_cnt + WC_W'(1);
            end
         end
         default: ;
      endcase

      // Branch beats load-use; the load-use bubble holds PC and IF/ID for one cycle
      if (use_prio) begin
         if (ex_BranchTaken) begin
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            flush_evt  = 1'b1;
         end else if (load_use) begin
            {idex_en, exmem_en, memwb_en} = 3'b111;
            idex_flush = 1'b1;
         end else begin
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
         end
      end

      if (!reset) begin
         {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
         {ifid_flush, idex_flush, exmem_flush, memwb_flush} = 4'b1111;
         dmem_req = 1'b0;
      end
   end

   assign stall_evt = (state != ERR) && !pc_en;

   // State, wait counter, sticky error and performance counters
   always_ff @(posedge clk) begin
      if (!reset) begin
         state        <= RUN;
         wait_cnt     <= '0;
         mem_err      <= 1'b0;
         stall_cycles <= '0;
         flush_count  <= '0;
      end else begin
         state    <= state_next;
         wait_cnt <= wait_next;
         mem_err  <= (state_next == ERR);
         if (stall_evt && (stall_cycles != '1))
            stall_cycles <= stall_cycles + CNT_W'(1);
         if (flush_evt && (flush_count != '1))
            flush_count <= flush_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboarded bench for pipe_hazard_ctrl: default-timeout instance plus a MEM_TIMEOUT=4 instance.
module tb_pipe_hazard_ctrl;

   localparam logic [9:0] RESET_V  = 10'b00000_1111_0;
   localparam logic [9:0] ALL_RUN  = 10'b11111_0000_0;
   localparam logic [9:0] FREEZE_R = 10'b00000_0000_1;
   localparam logic [9:0] RELEASE  = 10'b11111_0000_1;
   localparam logic [9:0] BRANCH   = 10'b11111_1100_0;
   localparam logic [9:0] BR_REL   = 10'b11111_1100_1;
   localparam logic [9:0] LOADUSE  = 10'b00111_0100_0;
   localparam logic [9:0] ERR_V    = 10'b00000_0000_0;

   logic clk = 1'b0;
   logic reset;
   logic idex_MemRead, ex_BranchTaken, exmem_MemRead, exmem_MemWrite, dmem_ready;
   logic [4:0] idex_Rt, ifid_Rs, ifid_Rt;

   logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
   logic ifid_flush, idex_flush, exmem_flush, memwb_flush, dmem_req, mem_err;
   logic [31:0] stall_cycles, flush_count;

   logic pc_en_t, ifid_en_t, idex_en_t, exmem_en_t, memwb_en_t;
   logic ifid_flush_t, idex_flush_t, exmem_flush_t, memwb_flush_t, dmem_req_t, mem_err_t;
   logic [31:0] stall_cycles_t, flush_count_t;

   logic [9:0] obs, obs_t, exp;
   logic [9:0] exp_q[$];
   int n_checks = 0;
   int n_fail   = 0;
   int exp_stall = 0;
   int exp_flush = 0;

   always #5 clk = ~clk;

   assign obs   = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                   ifid_flush, idex_flush, exmem_flush, memwb_flush, dmem_req};
   assign obs_t = {pc_en_t, ifid_en_t, idex_en_t, exmem_en_t, memwb_en_t,
                   ifid_flush_t, idex_flush_t, exmem_flush_t, memwb_flush_t, dmem_req_t};

   pipe_hazard_ctrl dut (
      .clk(clk), .reset(reset),
      .idex_MemRead(idex_MemRead), .idex_Rt(idex_Rt), .ifid_Rs(ifid_Rs), .ifid_Rt(ifid_Rt),
      .ex_BranchTaken(ex_BranchTaken), .exmem_MemRead(exmem_MemRead),
      .exmem_MemWrite(exmem_MemWrite), .dmem_ready(dmem_ready),
      .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
      .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
      .exmem_flush(exmem_flush), .memwb_flush(memwb_flush), .dmem_req(dmem_req),
      .mem_err(mem_err), .stall_cycles(stall_cycles), .flush_count(flush_count)
   );

   pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) dut_to (
      .clk(clk), .reset(reset),
      .idex_MemRead(idex_MemRead), .idex_Rt(idex_Rt), .ifid_Rs(ifid_Rs), .ifid_Rt(ifid_Rt),
      .ex_BranchTaken(ex_BranchTaken), .exmem_MemRead(exmem_MemRead),
      .exmem_MemWrite(exmem_MemWrite), .dmem_ready(dmem_ready),
      .pc_en(pc_en_t), .ifid_en(ifid_en_t), .idex_en(idex_en_t), .exmem_en(exmem_en_t),
      .memwb_en(memwb_en_t), .ifid_flush(ifid_flush_t), .idex_flush(idex_flush_t),
      .exmem_flush(exmem_flush_t), .memwb_flush(memwb_flush_t), .dmem_req(dmem_req_t),
      .mem_err(mem_err_t), .stall_cycles(stall_cycles_t), .flush_count(flush_count_t)
   );

   task automatic idle_inputs();
      idex_MemRead = 1'b0; idex_Rt = 5'd0; ifid_Rs = 5'd0; ifid_Rt = 5'd0;
      ex_BranchTaken = 1'b0; exmem_MemRead = 1'b0; exmem_MemWrite = 1'b0; dmem_ready = 1'b0;
   endtask

   task automatic do_reset();
      @(posedge clk); #1; reset = 1'b0; idle_inputs();
      @(posedge clk); #1; reset = 1'b1;
      exp_stall = 0; exp_flush = 0;
   endtask

   task automatic test_reset();
      reset = 1'b0; idle_inputs();
      repeat (2) @(posedge clk);
      #1; exp_q.push_back(RESET_V);
      @(negedge clk); exp = exp_q.pop_front();
      n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL reset_outputs: got %b want %b", obs, exp); end
      n_checks++; if (stall_cycles !== 32'd0 || flush_count !== 32'd0 || mem_err !== 1'b0) begin
         n_fail++; $display("FAIL reset_state: stall=%0d flush=%0d err=%b want 0 0 0", stall_cycles, flush_count, mem_err);
      end
      @(posedge clk); #1; reset = 1'b1;
      exp_q.push_back(ALL_RUN);
      @(negedge clk); exp = exp_q.pop_front();
      n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL reset_release: got %b want %b", obs, exp); end
   endtask

   task automatic test_load_use();
      @(posedge clk); #1; idle_inputs();
      idex_MemRead = 1'b1; idex_Rt = 5'd8; ifid_Rs = 5'd8;
      exp_q.push_back(LOADUSE); exp_stall++;
      @(negedge clk); exp = exp_q.pop_front();
      n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL load_use_stall: got %b want %b", obs, exp); end
      @(posedge clk); #1; idex_MemRead = 1'b0;
      exp_q.push_back(ALL_RUN);
      @(negedge clk); exp = exp_q.pop_front();
      n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL load_use_after: got %b want %b", obs, exp); end
      n_checks++; if (stall_cycles !== 32'(exp_stall)) begin n_fail++; $display("FAIL load_use_count: got %0d want %0d", stall_cycles, exp_stall); end
   endtask

   task automatic test_load_use_variants();
      logic [4:0] rt_t [3] = '{5'd0, 5'd5, 5'd5};
      logic [4:0] rs_t [3] = '{5'd0, 5'd6, 5'd6};
      logic [4:0] r2_t [3] = '{5'd0, 5'd5, 5'd7};
      logic [9:0] ex_t [3] = '{ALL_RUN, LOADUSE, ALL_RUN};
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1; idle_inputs();
         idex_MemRead = 1'b1; idex_Rt = rt_t[i]; ifid_Rs = rs_t[i]; ifid_Rt = r2_t[i];
         exp_q.push_back(ex_t[i]);
         if (ex_t[i] == LOADUSE) exp_stall++;
         @(negedge clk); exp = exp_q.pop_front();
         n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL load_use_variant%0d: got %b want %b", i, obs, exp); end
      end
      @(posedge clk); #1; idle_inputs();
      @(negedge clk);
      n_checks++; if (stall_cycles !== 32'(exp_stall)) begin n_fail++; $display("FAIL variant_count: got %0d want %0d", stall_cycles, exp_stall); end
   endtask

   task automatic test_branch_vs_load_use();
      @(posedge clk); #1; idle_inputs();
      ex_BranchTaken = 1'b1; idex_MemRead = 1'b1; idex_Rt = 5'd9; ifid_Rs = 5'd9;
      exp_q.push_back(BRANCH); exp_flush++;
      @(negedge clk); exp = exp_q.pop_front();
      n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL branch_priority: got %b want %b", obs, exp); end
      @(posedge clk); #1; idle_inputs();
      @(negedge clk);
      n_checks++; if (flush_count !== 32'(exp_flush) || stall_cycles !== 32'(exp_stall)) begin
         n_fail++; $display("FAIL branch_counts: flush=%0d stall=%0d want %0d %0d", flush_count, stall_cycles, exp_flush, exp_stall);
      end
   endtask

   task automatic test_mem_wait();
      logic [9:0] ex_t [5] = '{FREEZE_R, FREEZE_R, FREEZE_R, RELEASE, ALL_RUN};
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1; idle_inputs();
         exmem_MemRead = (i < 4); dmem_ready = (i == 3);
         exp_q.push_back(ex_t[i]);
         if (ex_t[i] == FREEZE_R) exp_stall++;
         @(negedge clk); exp = exp_q.pop_front();
         n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL mem_wait_cyc%0d: got %b want %b", i, obs, exp); end
      end
      n_checks++; if (stall_cycles !== 32'(exp_stall)) begin n_fail++; $display("FAIL mem_wait_count: got %0d want %0d", stall_cycles, exp_stall); end
   endtask

   task automatic test_branch_in_wait();
      logic [9:0] ex_t [4] = '{FREEZE_R, FREEZE_R, BR_REL, ALL_RUN};
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1; idle_inputs();
         exmem_MemRead = (i < 3); dmem_ready = (i == 2); ex_BranchTaken = (i < 3);
         exp_q.push_back(ex_t[i]);
         if (ex_t[i] == FREEZE_R) exp_stall++;
         if (ex_t[i] == BR_REL) exp_flush++;
         @(negedge clk); exp = exp_q.pop_front();
         n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL branch_wait_cyc%0d: got %b want %b", i, obs, exp); end
      end
      n_checks++; if (flush_count !== 32'(exp_flush) || stall_cycles !== 32'(exp_stall)) begin
         n_fail++; $display("FAIL branch_wait_counts: flush=%0d stall=%0d want %0d %0d", flush_count, stall_cycles, exp_flush, exp_stall);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1; idle_inputs();
         exmem_MemWrite = (i != 1); exmem_MemRead = (i == 1); dmem_ready = 1'b1;
         exp_q.push_back(RELEASE);
         @(negedge clk); exp = exp_q.pop_front();
         n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL zero_wait%0d: got %b want %b", i, obs, exp); end
      end
   endtask

   task automatic test_ready_beats_timeout();
      logic [9:0] ex_t [5] = '{FREEZE_R, FREEZE_R, FREEZE_R, RELEASE, ALL_RUN};
      do_reset();
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1; idle_inputs();
         exmem_MemWrite = (i < 4); dmem_ready = (i == 3);
         exp_q.push_back(ex_t[i]);
         @(negedge clk); exp = exp_q.pop_front();
         n_checks++; if (obs_t !== exp) begin n_fail++; $display("FAIL ready_vs_to_cyc%0d: got %b want %b", i, obs_t, exp); end
      end
      n_checks++; if (mem_err_t !== 1'b0 || stall_cycles_t !== 32'd3) begin
         n_fail++; $display("FAIL ready_vs_to_state: err=%b stall=%0d want 0 3", mem_err_t, stall_cycles_t);
      end
   endtask

   task automatic test_timeout();
      logic [9:0] ex_t [6] = '{FREEZE_R, FREEZE_R, FREEZE_R, FREEZE_R, ERR_V, ERR_V};
      do_reset();
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1; idle_inputs();
         exmem_MemWrite = 1'b1;
         exp_q.push_back(ex_t[i]);
         @(negedge clk); exp = exp_q.pop_front();
         n_checks++; if (obs_t !== exp) begin n_fail++; $display("FAIL timeout_cyc%0d: got %b want %b", i, obs_t, exp); end
         n_checks++; if (mem_err_t !== (i >= 4)) begin n_fail++; $display("FAIL timeout_err%0d: got %b want %b", i, mem_err_t, (i >= 4)); end
      end
      n_checks++; if (stall_cycles_t !== 32'd4) begin n_fail++; $display("FAIL timeout_stall: got %0d want 4", stall_cycles_t); end
      @(posedge clk); #1; reset = 1'b0; idle_inputs();
      exp_q.push_back(RESET_V);
      @(negedge clk); exp = exp_q.pop_front();
      n_checks++; if (obs_t !== exp) begin n_fail++; $display("FAIL timeout_reset_out: got %b want %b", obs_t, exp); end
      @(posedge clk); #1; reset = 1'b1; exp_stall = 0; exp_flush = 0;
      exp_q.push_back(ALL_RUN);
      @(negedge clk); exp = exp_q.pop_front();
      n_checks++; if (obs_t !== exp || mem_err_t !== 1'b0) begin
         n_fail++; $display("FAIL timeout_cleared: got %b err=%b want %b err=0", obs_t, mem_err_t, exp);
      end
   endtask

   task automatic test_reset_mid_wait();
      @(posedge clk); #1; idle_inputs(); ex_BranchTaken = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1; idle_inputs(); exmem_MemRead = 1'b1;
      end
      @(negedge clk);
      n_checks++; if (flush_count !== 32'd1 || stall_cycles !== 32'd1 || obs !== FREEZE_R) begin
         n_fail++; $display("FAIL mid_wait_pre: flush=%0d stall=%0d out=%b want 1 1 %b", flush_count, stall_cycles, obs, FREEZE_R);
      end
      @(posedge clk); #1; reset = 1'b0;
      @(posedge clk); #1; reset = 1'b1; idle_inputs();
      exp_q.push_back(ALL_RUN);
      @(negedge clk); exp = exp_q.pop_front();
      n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL mid_wait_out: got %b want %b", obs, exp); end
      n_checks++; if (flush_count !== 32'd0 || stall_cycles !== 32'd0 || mem_err !== 1'b0) begin
         n_fail++; $display("FAIL mid_wait_cleared: flush=%0d stall=%0d err=%b want 0 0 0", flush_count, stall_cycles, mem_err);
      end
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_load_use();
      test_load_use_variants();
      test_branch_vs_load_use();
      test_mem_wait();
      test_branch_in_wait();
      test_back_to_back();
      test_ready_beats_timeout();
      test_timeout();
      test_reset_mid_wait();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
